// File: rtl/dmem_request_unit.sv
// -----------------------------------------------------------------------------
// dmem_request_unit
//   Memory-stage controller for the pipelined RV32I core. Takes the EX/MEM
//   load/store request, drives a held read/write strobe to the data cache,
//   stalls the pipeline until the one-cycle cache response and returns the
//   byte/halfword/word load result, sign- or zero-extended.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_mem_read/write      request from the EX/MEM control word (write wins)
//   i_funct3              lb/lh/lw/lbu/lhu, sb/sh/sw width code
//   i_addr, i_wdata       byte address and unshifted store data
//   o_stall               freeze IF/ID/EX/MEM pipeline registers
//   o_load_data           extended load result (held until next load)
//   o_misaligned          current request is misaligned and dropped
//   o_dmem_*              cache request: strobes, word address, mask, data
//   i_dmem_rdata/resp     cache read data and one-cycle response pulse
//   o_stall_count         saturating count of stalled cycles
// -----------------------------------------------------------------------------
module dmem_request_unit #(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_mem_read,
    input  logic                   i_mem_write,
    input  logic [2:0]             i_funct3,
    input  logic [31:0]            i_addr,
    input  logic [31:0]            i_wdata,
    output logic                   o_stall,
    output logic [31:0]            o_load_data,
    output logic                   o_misaligned,
    output logic                   o_dmem_read,
    output logic                   o_dmem_write,
    output logic [31:0]            o_dmem_address,
    output logic [3:0]             o_dmem_wmask,
    output logic [31:0]            o_dmem_wdata,
    input  logic [31:0]            i_dmem_rdata,
    input  logic                   i_dmem_resp,
    output logic [STALL_CNT_W-1:0] o_stall_count
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    // Request attributes needed after the inputs may have moved on:
    // load extension uses funct3 and the byte offset of the original address.
    typedef struct packed {
        logic       is_write;
        logic [2:0] funct3;
        logic [1:0] off;
    } req_t;

    state_t                 r_state, w_state_nxt;
    req_t                   r_req;
    logic                   r_dmem_read, r_dmem_write;
    logic [31:0]            r_dmem_address, r_dmem_wdata, r_load_data;
    logic [3:0]             r_dmem_wmask;
    logic [STALL_CNT_W-1:0] r_stall_count;

    logic                   w_req, w_mis_raw, w_accept;
    logic [1:0]             w_off, w_size;
    logic [3:0]             w_wmask;
    logic [31:0]            w_wlanes, w_rshift, w_load_ext;

    // ---------------- request decode ----------------
    assign w_req  = i_mem_read | i_mem_write;
    assign w_off  = i_addr[1:0];
    assign w_size = i_funct3[1:0];   // 00 byte, 01 half, 1x word

    assign w_mis_raw    = ((w_size == 2'b01) & w_off[0]) | (w_size[1] & (w_off != 2'b00));
    assign o_misaligned = w_req & w_mis_raw;
    assign w_accept     = w_req & ~w_mis_raw;

    always_comb begin
        w_wmask  = 4'hF;
        w_wlanes = i_wdata;
        case (w_size)
            2'b00: begin
                w_wmask  = 4'b0001 << w_off;
                w_wlanes = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_wmask  = 4'b0011 << w_off;
                w_wlanes = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // ---------------- load extension ----------------
    // Bring the addressed byte/halfword down to bit 0, then extend.
    assign w_rshift = i_dmem_rdata >> {r_req.off, 3'b000};

    always_comb begin
        w_load_ext = i_dmem_rdata;
        case (r_req.funct3)
            3'b000:  w_load_ext = {{24{w_rshift[7]}},  w_rshift[7:0]};
            3'b001:  w_load_ext = {{16{w_rshift[15]}}, w_rshift[15:0]};
            3'b100:  w_load_ext = {24'd0, w_rshift[7:0]};
            3'b101:  w_load_ext = {16'd0, w_rshift[15:0]};
            default: w_load_ext = i_dmem_rdata;
        endcase
    end

    // ---------------- FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        o_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Stall combinationally in the first cycle so the pipeline
                // holds the request while the cache strobe is registered.
                o_stall = w_accept;
                if (w_accept) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                o_stall = 1'b1;
                if (i_dmem_resp) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                // One free cycle: pipeline advances, next request is not
                // sampled until we are back in IDLE.
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_req          <= '0;
            r_dmem_read    <= 1'b0;
            r_dmem_write   <= 1'b0;
            r_dmem_address <= '0;
            r_dmem_wmask   <= '0;
            r_dmem_wdata   <= '0;
            r_load_data    <= '0;
            r_stall_count  <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_IDLE && w_accept) begin
                r_req.is_write <= i_mem_write;
                r_req.funct3   <= i_funct3;
                r_req.off      <= w_off;
                r_dmem_read    <= ~i_mem_write;
                r_dmem_write   <= i_mem_write;
                r_dmem_address <= {i_addr[31:2], 2'b00};
                r_dmem_wmask   <= w_wmask;
                r_dmem_wdata   <= w_wlanes;
            end

            if (r_state == S_BUSY && i_dmem_resp) begin
                r_dmem_read  <= 1'b0;
                r_dmem_write <= 1'b0;
                if (!r_req.is_write) r_load_data <= w_load_ext;
            end

            if (o_stall && (r_stall_count != '1))
                r_stall_count <= r_stall_count + STALL_CNT_W'(1);
        end
    end

    assign o_dmem_read    = r_dmem_read;
    assign o_dmem_write   = r_dmem_write;
    assign o_dmem_address = r_dmem_address;
    assign o_dmem_wmask   = r_dmem_wmask;
    assign o_dmem_wdata   = r_dmem_wdata;
    assign o_load_data    = r_load_data;
    assign o_stall_count  = r_stall_count;

endmodule

// File: tb/tb_dmem_request_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_request_unit
//   Self-checking bench for dmem_request_unit. A fixed vector table covers the
//   documented load/store cases, hand sequences cover reset during a busy
//   request and back-to-back loads, and a random loop is checked against a
//   small arithmetic reference model. A narrow stall counter is used so that
//   saturation is reached within the run.
// -----------------------------------------------------------------------------
module tb_dmem_request_unit;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write;
    logic [2:0]    funct3;
    logic [31:0]   addr, wdata;
    logic          stall, misaligned, dmem_read, dmem_write;
    logic [31:0]   load_data, dmem_address, dmem_wdata, dmem_rdata;
    logic [3:0]    dmem_wmask;
    logic          dmem_resp;
    logic [CW-1:0] stall_count;

    always #5 clk = ~clk;

    dmem_request_unit #(.STALL_CNT_W(CW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_mem_read     (mem_read),
        .i_mem_write    (mem_write),
        .i_funct3       (funct3),
        .i_addr         (addr),
        .i_wdata        (wdata),
        .o_stall        (stall),
        .o_load_data    (load_data),
        .o_misaligned   (misaligned),
        .o_dmem_read    (dmem_read),
        .o_dmem_write   (dmem_write),
        .o_dmem_address (dmem_address),
        .o_dmem_wmask   (dmem_wmask),
        .o_dmem_wdata   (dmem_wdata),
        .i_dmem_rdata   (dmem_rdata),
        .i_dmem_resp    (dmem_resp),
        .o_stall_count  (stall_count)
    );

    int          checks = 0;
    int          errors = 0;
    int          cnt_m  = 0;        // model of stall_count
    logic [31:0] last_ld = 32'd0;   // model of load_data

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdat;
        int          dly;
        bit          mis;
        logic [3:0]  mask;
        logic [31:0] ewd;
        logic [31:0] eld;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic inc_cnt();
        if (cnt_m < CMAX) cnt_m++;
    endtask

    task automatic go_idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        step();
    endtask

    // Reference model: expected cache-side mask/data and load result straight
    // from the access-size rules, using plain shifts and multiplies.
    task automatic model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdat,
                         output bit mis, output logic [3:0] m,
                         output logic [31:0] ewd, output logic [31:0] eld);
        int          o;
        logic [31:0] sh;
        o   = int'(a[1:0]);
        mis = ((f3[1:0] == 2'd1) && (o % 2 != 0)) || ((f3[1:0] == 2'd2) && (o != 0));
        case (f3[1:0])
            2'd0:    begin m = 4'(1 << o); ewd = (wd & 32'hFF)   * 32'h0101_0101; end
            2'd1:    begin m = 4'(3 << o); ewd = (wd & 32'hFFFF) * 32'h0001_0001; end
            default: begin m = 4'hF;       ewd = wd;                              end
        endcase
        sh  = rdat >> (8 * o);
        eld = last_ld;
        if (!wr) begin
            case (f3)
                3'b000:  eld = (sh & 32'h80)   != 0 ? (sh | 32'hFFFF_FF00) : (sh & 32'hFF);
                3'b001:  eld = (sh & 32'h8000) != 0 ? (sh | 32'hFFFF_0000) : (sh & 32'hFFFF);
                3'b100:  eld = sh & 32'hFF;
                3'b101:  eld = sh & 32'hFFFF;
                default: eld = rdat;
            endcase
        end
    endtask

    // One complete request. Called just after a rising edge (cycle T) and
    // returns just after the rising edge that ends the DONE cycle, leaving the
    // request still on the inputs as a held pipeline would.
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input int dly, input bit mis,
                           input logic [3:0] mask, input logic [31:0] ewd,
                           input logic [31:0] eld);
        logic [31:0] prev_ld;
        prev_ld   = last_ld;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        dmem_resp = 1'b0;
        @(negedge clk);
        chk("misaligned_T", {31'd0, misaligned}, {31'd0, mis});
        chk("stall_T", {31'd0, stall}, {31'd0, !mis});
        chk("rd_strobe_T", {31'd0, dmem_read}, 32'd0);
        chk("wr_strobe_T", {31'd0, dmem_write}, 32'd0);
        if (mis) begin
            step();
            @(negedge clk);
            chk("mis_stall", {31'd0, stall}, 32'd0);
            chk("mis_no_strobe", {30'd0, dmem_read, dmem_write}, 32'd0);
            chk("mis_load", load_data, prev_ld);
            chk("mis_count", {28'd0, stall_count}, 32'(cnt_m));
            step();
            return;
        end
        inc_cnt();
        for (int k = 0; k <= dly; k++) begin
            step();
            dmem_resp  = (k == dly);
            dmem_rdata = rdat;
            @(negedge clk);
            inc_cnt();
            chk("busy_rd", {31'd0, dmem_read}, {31'd0, rd & !wr});
            chk("busy_wr", {31'd0, dmem_write}, {31'd0, wr});
            chk("busy_stall", {31'd0, stall}, 32'd1);
            if (k == 0) begin
                chk("busy_addr", dmem_address, a & 32'hFFFF_FFFC);
                chk("busy_mask", {28'd0, dmem_wmask}, {28'd0, mask});
                chk("busy_wdata", dmem_wdata, ewd);
                chk("busy_load_held", load_data, prev_ld);
            end
        end
        step();
        dmem_resp  = 1'b0;
        dmem_rdata = $urandom;
        @(negedge clk);
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
        chk("done_load", load_data, eld);
        chk("done_count", {28'd0, stall_count}, 32'(cnt_m));
        if (rd && !wr) last_ld = eld;
        step();
    endtask

    initial begin
        bit          r_rd, r_wr, r_mis;
        logic [2:0]  r_f3;
        logic [31:0] r_a, r_wd, r_rdat, r_ewd, r_eld;
        logic [3:0]  r_m;
        int          sel;

        //         rd wr f3      addr          wdata         rdata         dly mis mask     ewd           eld
        tbl[0]  = '{1, 0, 3'b010, 32'h1000_0008, 32'h0,        32'hDEAD_BEEF, 0, 0, 4'hF,    32'h0,        32'hDEAD_BEEF};
        tbl[1]  = '{1, 0, 3'b000, 32'h0000_0023, 32'h0,        32'h80FF_7F01, 0, 0, 4'b1000, 32'h0,        32'hFFFF_FF80};
        tbl[2]  = '{1, 0, 3'b100, 32'h0000_0023, 32'h0,        32'h80FF_7F01, 1, 0, 4'b1000, 32'h0,        32'h0000_0080};
        tbl[3]  = '{0, 1, 3'b001, 32'h0000_0042, 32'h1234_ABCD, 32'h5555_5555, 3, 0, 4'b1100, 32'hABCD_ABCD, 32'h0000_0080};
        tbl[4]  = '{1, 0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 1, 4'h0,    32'h0,        32'h0000_0080};
        tbl[5]  = '{1, 0, 3'b001, 32'h0000_0022, 32'h0,        32'h80FF_7F01, 0, 0, 4'b1100, 32'h0,        32'hFFFF_80FF};
        tbl[6]  = '{1, 0, 3'b101, 32'h0000_0020, 32'h0,        32'h80FF_7F01, 2, 0, 4'b0011, 32'h0,        32'h0000_7F01};
        tbl[7]  = '{0, 1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 32'h0,        0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_7F01};
        tbl[8]  = '{0, 1, 3'b001, 32'h0000_0043, 32'h1111_2222, 32'h0,        0, 1, 4'h0,    32'h0,        32'h0000_7F01};
        tbl[9]  = '{0, 1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,        1, 0, 4'hF,    32'hCAFE_F00D, 32'h0000_7F01};
        tbl[10] = '{1, 0, 3'b000, 32'h0000_0021, 32'h0,        32'h80FF_7F01, 0, 0, 4'b0010, 32'h0,        32'h0000_007F};
        tbl[11] = '{1, 1, 3'b010, 32'h0000_0030, 32'h1122_3344, 32'hFFFF_FFFF, 0, 0, 4'hF,    32'h1122_3344, 32'h0000_007F};

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
        addr = 32'h0; wdata = 32'h0; dmem_rdata = 32'h0; dmem_resp = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
        chk("rst_addr", dmem_address, 32'd0);
        chk("rst_mask", {28'd0, dmem_wmask}, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_count", {28'd0, stall_count}, 32'd0);
        step();

        // Documented vectors.
        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rdat,
                    tbl[i].dly, tbl[i].mis, tbl[i].mask, tbl[i].ewd, tbl[i].eld);
            go_idle();
        end

        // Back-to-back loads: the second is presented in the cycle right after
        // DONE; its strobe must first appear one cycle later.
        run_txn(1, 0, 3'b010, 32'h0000_0300, 32'h0, 32'h1111_1111, 0, 0, 4'hF, 32'h0, 32'h1111_1111);
        run_txn(1, 0, 3'b010, 32'h0000_0304, 32'h0, 32'h2222_2222, 0, 0, 4'hF, 32'h0, 32'h2222_2222);
        go_idle();

        // Reset while BUSY abandons the request.
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0080;
        step();
        @(negedge clk);
        chk("pre_rst_busy_rd", {31'd0, dmem_read}, 32'd1);
        rst = 1'b1;
        mem_read = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        cnt_m   = 0;
        last_ld = 32'd0;
        chk("midrst_strobes", {30'd0, dmem_read, dmem_write}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_count", {28'd0, stall_count}, 32'd0);
        chk("midrst_addr", dmem_address, 32'd0);
        chk("midrst_load", load_data, 32'd0);
        step();
        @(negedge clk);
        chk("midrst_idle_stall", {31'd0, stall}, 32'd0);
        chk("midrst_idle_rd", {31'd0, dmem_read}, 32'd0);
        step();
        run_txn(1, 0, 3'b010, 32'h0000_0084, 32'h0, 32'h7654_3210, 1, 0, 4'hF, 32'h0, 32'h7654_3210);
        go_idle();

        // Random traffic against the model.
        for (int n = 0; n < 60; n++) begin
            sel  = int'($urandom_range(0, 9));
            r_rd = (sel <= 4) || (sel == 9);
            r_wr = (sel >= 5);
            if (r_wr) begin
                r_f3 = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0: r_f3 = 3'b000;
                    1: r_f3 = 3'b001;
                    2: r_f3 = 3'b010;
                    3: r_f3 = 3'b100;
                    default: r_f3 = 3'b101;
                endcase
            end
            r_a    = $urandom;
            r_wd   = $urandom;
            r_rdat = $urandom;
            model(r_wr, r_f3, r_a, r_wd, r_rdat, r_mis, r_m, r_ewd, r_eld);
            run_txn(r_rd, r_wr, r_f3, r_a, r_wd, r_rdat, int'($urandom_range(0, 3)),
                    r_mis, r_m, r_ewd, r_eld);
            if ($urandom_range(0, 1) == 1) go_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
